// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// States, opcode constants, mux encodings and the decoded control vector.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ      = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // pc_write_fetch and ir_write are qualified by mem_ready in the top
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_fetch;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       done;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bus: IR fields, status flags and all control lines.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
  );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> control-vector decoder (Moore part of the controller).
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read       = 1'b1;
        ctrl.alu_src_b      = SRCB_FOUR;
        ctrl.alu_op         = ALUOP_ADD;
        ctrl.pc_source      = PCSRC_ALU;
        ctrl.ir_write       = 1'b1;
        ctrl.pc_write_fetch = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_RTYPE_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      S_HALT:    ctrl.done      = 1'b1;
      default:   ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register, next-state decode, sticky flags.
// Optional perf counters (cycle_cnt, instr_cnt) under MIPS_CTRL_PERF_CNT_EN.
//
// state      | meaning
// FETCH      | read instruction at PC, PC+4 -> PC on mem_ready
// DECODE     | read regs, precompute branch target
// MEMADR     | ALU computes A + signext(imm)
// MEMRD      | load access, waits for mem_ready
// MEMWB      | MDR -> rt
// MEMWR      | store access, waits for mem_ready
// RTYPE_EX   | ALU op from funct
// RTYPE_WB   | ALUOut -> rd
// BEQ        | compare, branch if zero
// JUMP       | jump target -> PC
// ADDI_EX    | A + signext(imm)
// ADDI_WB    | ALUOut -> rt
// HALT       | Done, terminal until reset
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = 6'h3F
`ifdef MIPS_CTRL_PERF_CNT_EN
  , parameter int       CNT_W       = 32
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  mips_multicycle_ctrl_if.master    bus,
  output logic                      Done,
  output logic                      illegal,
  output logic [3:0]                state
`ifdef MIPS_CTRL_PERF_CNT_EN
  , output logic [CNT_W-1:0]        cycle_cnt
  , output logic [CNT_W-1:0]        instr_cnt
`endif
);

  state_t cur, nxt;
  ctrl_t  ctrl;
  logic   illegal_set;
  logic   unused_funct;

  // funct is decoded by the datapath ALU control, not here
  assign unused_funct = ^bus.funct;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_FETCH;
    else        cur <= nxt;
  end

  always_comb begin
    nxt         = S_FETCH;
    illegal_set = 1'b0;
    case (cur)
      S_FETCH:    nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (bus.opcode == OP_LW || bus.opcode == OP_SW) nxt = S_MEMADR;
        else if (bus.opcode == OP_RTYPE)                nxt = S_RTYPE_EX;
        else if (bus.opcode == OP_BEQ)                  nxt = S_BEQ;
        else if (bus.opcode == OP_J)                    nxt = S_JUMP;
        else if (bus.opcode == OP_ADDI)                 nxt = S_ADDI_EX;
        else if (bus.opcode == HALT_OPCODE)             nxt = S_HALT;
        else begin
          nxt         = S_FETCH;
          illegal_set = 1'b1;
        end
      end
      S_MEMADR:   nxt = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: nxt = S_RTYPE_WB;
      S_ADDI_EX:  nxt = S_ADDI_WB;
      S_HALT:     nxt = S_HALT;
      default:    nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           illegal <= 1'b0;
    else if (illegal_set) illegal <= 1'b1;
  end

  mips_ctrl_outdec u_outdec (
    .state (cur),
    .ctrl  (ctrl)
  );

  // Outputs are forced low while reset is held so no access starts mid-reset
  assign bus.pc_en    = reset & (ctrl.pc_write
                               | (ctrl.pc_write_fetch & bus.mem_ready)
                               | (ctrl.pc_write_cond & bus.zero));
  assign bus.IRWrite  = reset & ctrl.ir_write & bus.mem_ready;
  assign bus.IorD     = reset & ctrl.iord;
  assign bus.MemRead  = reset & ctrl.mem_read;
  assign bus.MemWrite = reset & ctrl.mem_write;
  assign bus.RegDst   = reset & ctrl.reg_dst;
  assign bus.MemtoReg = reset & ctrl.mem_to_reg;
  assign bus.RegWrite = reset & ctrl.reg_write;
  assign bus.ALUSrcA  = reset & ctrl.alu_src_a;
  assign bus.ALUSrcB  = reset ? ctrl.alu_src_b : 2'd0;
  assign bus.ALUOp    = reset ? ctrl.alu_op    : 2'd0;
  assign bus.PCSource = reset ? ctrl.pc_source : 2'd0;
  assign Done         = reset & ctrl.done;
  assign state        = cur;

`ifdef MIPS_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (cur != S_HALT) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (cur == S_DECODE && nxt != S_FETCH) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
